// File: rtl/key_pulse_ctrl_if.sv
// Key pulse controller signal bundle: debounced key and repeat enable in; command pulses,
// held level and press count out.
interface key_pulse_ctrl_if;
    logic       Key_xi;
    logic       Rep_en_xi;
    logic       Pulse_xo;
    logic       Release_xo;
    logic       Held_xo;
    logic [7:0] Press_cnt_xo;

    modport master (
        output Key_xi,
        output Rep_en_xi,
        input  Pulse_xo,
        input  Release_xo,
        input  Held_xo,
        input  Press_cnt_xo
    );

    modport slave (
        input  Key_xi,
        input  Rep_en_xi,
        output Pulse_xo,
        output Release_xo,
        output Held_xo,
        output Press_cnt_xo
    );
endinterface

// File: rtl/key_pulse_ctrl.sv
// Turns a debounced key level into one-cycle press/repeat/release pulses for the
// instruction fetch logic, with a long-press held flag and an 8-bit press count.
module key_pulse_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES = 10000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    key_pulse_ctrl_if.slave kp
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPress  = 2'd1,
        StRepeat = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             k1_q, k2_q;
    logic             ks;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             held_q, held_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    assign ks = k2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;

        case (state_q)
            StIdle: begin
                if (ks) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StPress;
                end
            end
            StPress: begin
                if (!ks) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_q == HoldLast) begin
                    held_d  = 1'b1;
                    pulse_d = kp.Rep_en_xi;
                    cnt_d   = '0;
                    state_d = StRepeat;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRepeat: begin
                // Release takes priority over a repeat falling due on the same edge
                if (!ks) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (cnt_q == RepeatLast) begin
                    pulse_d = kp.Rep_en_xi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase

        press_cnt_d = press_cnt_q + 8'(pulse_d);
        if (state_q != StIdle && state_q != StPress && state_q != StRepeat) begin
            press_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            k1_q        <= 1'b0;
            k2_q        <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            release_q   <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            k1_q        <= kp.Key_xi;
            k2_q        <= k1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            release_q   <= release_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign kp.Pulse_xo     = pulse_q;
    assign kp.Release_xo   = release_q;
    assign kp.Held_xo      = held_q;
    assign kp.Press_cnt_xo = press_cnt_q;

endmodule

// File: tb/tb_key_pulse_ctrl.sv
// Bench for key_pulse_ctrl: vector table, timed press sequences and random key traffic
// checked against an age-since-press reference model.
module tb_key_pulse_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    key_pulse_ctrl_if kp ();

    key_pulse_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (16)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .kp (kp.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: key history plus time elapsed since the press pulse
    bit         m_k1, m_k2, m_down, m_held, m_pulse, m_rel;
    int         m_age;
    logic [7:0] m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_k1 = 0; m_k2 = 0; m_down = 0; m_held = 0; m_pulse = 0; m_rel = 0;
        m_age = 0; m_cnt = 8'd0;
    endtask

    task automatic model_edge();
        bit ks;
        ks      = m_k2;
        m_k2    = m_k1;
        m_k1    = kp.Key_xi;
        m_pulse = 0;
        m_rel   = 0;
        if (!m_down) begin
            if (ks) begin
                m_pulse = 1; m_down = 1; m_age = 0;
            end
        end else begin
            m_age++;
            if (!ks) begin
                m_rel = 1; m_down = 0; m_held = 0;
            end else if (m_age >= HOLD) begin
                m_held = 1;
                if (((m_age - HOLD) % REP) == 0) m_pulse = kp.Rep_en_xi;
            end
        end
        if (m_pulse) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        cyc++;
        #1;
        check("pulse", 32'(kp.Pulse_xo), 32'(m_pulse));
        check("release", 32'(kp.Release_xo), 32'(m_rel));
        check("held", 32'(kp.Held_xo), 32'(m_held));
        check("press_cnt", 32'(kp.Press_cnt_xo), 32'(m_cnt));
        check("pulse_release_excl", 32'(kp.Pulse_xo & kp.Release_xo), 32'd0);
    endtask

    task automatic do_reset();
        kp.Key_xi = 0;
        Rst = 1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Rst = 0;
    endtask

    int p_offs[$];
    int r_offs[$];
    int held_rise;
    int p0;

    task automatic press_seq(input int n_high, input bit rep, input int tail);
        bit hprev;
        hprev = 0; p0 = -1; held_rise = -1;
        p_offs.delete();
        r_offs.delete();
        kp.Rep_en_xi = rep;
        for (int i = 0; i < n_high + tail; i++) begin
            kp.Key_xi = (i < n_high);
            tick();
            if (kp.Pulse_xo) begin
                if (p0 < 0) p0 = cyc;
                p_offs.push_back(cyc - p0);
            end
            if (kp.Release_xo) r_offs.push_back(cyc - p0);
            if (kp.Held_xo && !hprev && held_rise < 0) held_rise = cyc - p0;
            hprev = kp.Held_xo;
        end
    endtask

    typedef struct {
        bit         key;
        bit         p;
        bit         r;
        bit         h;
        logic [7:0] c;
    } vec_t;

    vec_t tbl[7];
    int   exp3[5];
    bit   lvl;
    int   len;

    initial begin
        // Short press, 3 key cycles: pulse at edge 2 (P), release at P+3
        tbl[0] = '{1, 0, 0, 0, 8'd0};
        tbl[1] = '{1, 0, 0, 0, 8'd0};
        tbl[2] = '{1, 1, 0, 0, 8'd1};
        tbl[3] = '{0, 0, 0, 0, 8'd1};
        tbl[4] = '{0, 0, 0, 0, 8'd1};
        tbl[5] = '{0, 0, 1, 0, 8'd1};
        tbl[6] = '{0, 0, 0, 0, 8'd1};
        exp3 = '{0, 8, 12, 16, 20};

        kp.Key_xi = 0;
        kp.Rep_en_xi = 1;
        Rst = 1;
        #1;
        check("reset_pulse", 32'(kp.Pulse_xo), 32'd0);
        check("reset_cnt", 32'(kp.Press_cnt_xo), 32'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            kp.Key_xi = tbl[i].key;
            tick();
            check("tbl_pulse", 32'(kp.Pulse_xo), 32'(tbl[i].p));
            check("tbl_release", 32'(kp.Release_xo), 32'(tbl[i].r));
            check("tbl_held", 32'(kp.Held_xo), 32'(tbl[i].h));
            check("tbl_cnt", 32'(kp.Press_cnt_xo), 32'(tbl[i].c));
        end

        // Long hold with repeat
        do_reset();
        press_seq(22, 1, 6);
        check("rep_npulses", 32'(p_offs.size()), 32'd5);
        for (int i = 0; i < 5 && i < p_offs.size(); i++) check("rep_offset", p_offs[i], exp3[i]);
        check("rep_held_rise", held_rise, 32'd8);
        check("rep_nrel", 32'(r_offs.size()), 32'd1);
        if (r_offs.size() > 0) check("rep_rel_offset", r_offs[0], 32'd22);
        check("rep_cnt", 32'(kp.Press_cnt_xo), 32'd5);

        // Long hold with repeat disabled
        do_reset();
        press_seq(22, 0, 6);
        check("norep_npulses", 32'(p_offs.size()), 32'd1);
        check("norep_held_rise", held_rise, 32'd8);
        check("norep_nrel", 32'(r_offs.size()), 32'd1);
        check("norep_cnt", 32'(kp.Press_cnt_xo), 32'd1);

        // Release lands on the edge a repeat is due
        do_reset();
        press_seq(12, 1, 6);
        check("race_npulses", 32'(p_offs.size()), 32'd2);
        if (p_offs.size() > 1) check("race_last_pulse", p_offs[p_offs.size()-1], 32'd8);
        if (r_offs.size() > 0) check("race_rel_offset", r_offs[0], 32'd12);
        check("race_cnt", 32'(kp.Press_cnt_xo), 32'd2);

        // Asynchronous reset mid-hold with key still down
        do_reset();
        kp.Key_xi = 1;
        kp.Rep_en_xi = 1;
        repeat (12) tick();
        check("pre_rst_held", 32'(kp.Held_xo), 32'd1);
        #2;
        Rst = 1;
        #1;
        model_reset();
        check("async_held", 32'(kp.Held_xo), 32'd0);
        check("async_cnt", 32'(kp.Press_cnt_xo), 32'd0);
        check("async_pulse", 32'(kp.Pulse_xo), 32'd0);
        check("async_release", 32'(kp.Release_xo), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 0;
        tick();
        check("rst_edge1_pulse", 32'(kp.Pulse_xo), 32'd0);
        tick();
        check("rst_edge2_pulse", 32'(kp.Pulse_xo), 32'd0);
        tick();
        check("rst_edge3_pulse", 32'(kp.Pulse_xo), 32'd1);
        check("rst_edge3_cnt", 32'(kp.Press_cnt_xo), 32'd1);

        // Counter wrap with minimum-length presses
        do_reset();
        for (int n = 0; n < 256; n++) begin
            kp.Key_xi = 1; tick();
            kp.Key_xi = 0; repeat (3) tick();
        end
        check("wrap_cnt0", 32'(kp.Press_cnt_xo), 32'd0);
        kp.Key_xi = 1; tick();
        kp.Key_xi = 0; repeat (3) tick();
        check("wrap_cnt1", 32'(kp.Press_cnt_xo), 32'd1);

        // Random key runs with a toggling repeat enable
        do_reset();
        lvl = 0;
        for (int r = 0; r < 150; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                kp.Key_xi = lvl;
                if ($urandom_range(0, 7) == 0) kp.Rep_en_xi = ~kp.Rep_en_xi;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
